// File: rtl/rf_dump_reader.sv
// Register-file dump reader: walks every address through a spare read port and streams {addr, data} beats.
// Optional build macro RF_DUMP_SKIP_ZERO_EN suppresses beats whose register value is zero.
module rf_dump_reader #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] rd_addr,
  input  logic [D_WIDTH-1:0] rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] out_addr,
  output logic [D_WIDTH-1:0] out_data,
  output logic [A_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  localparam logic [A_WIDTH-1:0] LAST_IDX = {A_WIDTH{1'b1}};

  state_t             state, state_nx;
  logic [A_WIDTH-1:0] idx, idx_nx;
  logic [A_WIDTH-1:0] rd_addr_nx, out_addr_nx;
  logic [D_WIDTH-1:0] out_data_nx;
  logic [A_WIDTH:0]   word_count_nx;
  logic               out_valid_nx, busy_nx, done_nx;
  logic               skip_word;

`ifdef RF_DUMP_SKIP_ZERO_EN
  assign skip_word = (rd_data == {D_WIDTH{1'b0}});
`else
  assign skip_word = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      word_count <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      rd_addr    <= rd_addr_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      out_valid  <= out_valid_nx;
      out_addr   <= out_addr_nx;
      out_data   <= out_data_nx;
      word_count <= word_count_nx;
    end
  end

  // All outputs are computed here one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    rd_addr_nx    = rd_addr;
    out_valid_nx  = out_valid;
    out_addr_nx   = out_addr;
    out_data_nx   = out_data;
    word_count_nx = word_count;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx      = READ;
          idx_nx        = '0;
          rd_addr_nx    = '0;
          word_count_nx = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      READ: begin
        if (skip_word) begin
          if (idx == LAST_IDX) begin
            state_nx = FIN;
          end else begin
            idx_nx     = idx + A_WIDTH'(1);
            rd_addr_nx = idx + A_WIDTH'(1);
          end
        end else begin
          out_data_nx  = rd_data;
          out_addr_nx  = idx;
          out_valid_nx = 1'b1;
          state_nx     = SEND;
        end
      end
      SEND: begin
        if (out_valid && out_ready) begin
          word_count_nx = word_count + (A_WIDTH + 1)'(1);
          out_valid_nx  = 1'b0;
          if (idx == LAST_IDX) begin
            state_nx = FIN;
          end else begin
            idx_nx     = idx + A_WIDTH'(1);
            rd_addr_nx = idx + A_WIDTH'(1);
            state_nx   = READ;
          end
        end else begin
          state_nx = SEND;
        end
      end
      FIN: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx     = IDLE;
        out_valid_nx = 1'b0;
      end
    endcase
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == FIN);
  end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Scoreboard bench for rf_dump_reader: a register-file model feeds rd_data, expected beats are
// queued when a dump is issued and a negedge monitor pops and compares every accepted beat.
module tb_rf_dump_reader;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, done, out_valid;
  logic [AW-1:0] rd_addr, out_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [AW:0]   word_count;

  logic [DW-1:0] rf     [N];
  logic [DW-1:0] exp_rf [N];
  logic [AW+DW-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_count = 0;
  int done_before = 0;
  int exp_words = 0;
  int beats_seen = 0;
  int ready_mode = 0;
  bit timed_chk = 1'b0;

  assign rd_data = rf[rd_addr];

  rf_dump_reader #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink readiness pattern, changed just after each rising edge.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 3;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (ph == 0);
        2: out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshakes, stall stability and done pulses, sampled on the falling edge.
  initial begin
    bit prev_stall = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'(1));
          check("stall_addr", 64'(out_addr), 64'(prev_addr));
          check("stall_data", 64'(out_data), 64'(prev_data));
        end
        if (out_valid && out_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'(out_addr), 64'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat_addr", 64'(out_addr), 64'(e[AW+DW-1:DW]));
            check("beat_data", 64'(out_data), 64'(e[DW-1:0]));
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = out_valid;
        end
        prev_addr = out_addr;
        prev_data = out_data;
      end
      if (done) begin
        done_count++;
        check("done_word_count", 64'(word_count), 64'(exp_words));
        check("done_beats", 64'(beats_seen), 64'(exp_words));
        check("done_queue_empty", 64'(exp_q.size()), 64'(0));
        if (timed_chk) check("done_latency", 64'(cyc - start_cyc), 64'(64));
      end
    end
  end

  // Queue the expected stream from exp_rf, then pulse start.
  task automatic issue_dump();
    exp_words  = 0;
    beats_seen = 0;
    for (int i = 0; i < N; i++) begin
`ifdef RF_DUMP_SKIP_ZERO_EN
      if (exp_rf[i] != '0)
`endif
      begin
        exp_q.push_back({AW'(i), exp_rf[i]});
        exp_words++;
      end
    end
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    start_cyc   = cyc;
    done_before = done_count;
  endtask

  task automatic finish_dump(input string name);
    int n = 0;
    while (done_count == done_before && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (5) @(negedge clk);
    #1;
    check({name, "_one_done"}, 64'(done_count), 64'(done_before + 1));
    check({name, "_idle"}, 64'(busy), 64'(0));
    check({name, "_wc_hold"}, 64'(word_count), 64'(exp_words));
  endtask

  task automatic snap();
    for (int i = 0; i < N; i++) exp_rf[i] = rf[i];
  endtask

  initial begin
    for (int i = 0; i < N; i++) rf[i] = 32'h1000_0000 + DW'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_addr", 64'(out_addr), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_rd_addr", 64'(rd_addr), 64'(0));
    check("rst_wc", 64'(word_count), 64'(0));
    rst = 1'b0;

    // Sequential pattern, sink always ready, timed.
    ready_mode = 0;
    timed_chk = 1'b1;
    snap();
    issue_dump();
    finish_dump("seq");
    timed_chk = 1'b0;

    // Sink ready one cycle in three.
    rf[10] = 32'hDEAD_BEEF;
    ready_mode = 1;
    snap();
    issue_dump();
    finish_dump("stall");

    // Start re-pulsed while busy is ignored.
    ready_mode = 0;
    snap();
    issue_dump();
    repeat (3) begin
      repeat (7) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    finish_dump("repulse");

    // Reset mid-dump while beat 5 waits in SEND.
    snap();
    issue_dump();
    begin
      int n = 0;
      while (!(out_valid && out_addr == AW'(5)) && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("reach_beat5", 64'(out_addr), 64'(5));
    end
    rst = 1'b1;
    ready_mode = 2;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_wc", 64'(word_count), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_no_done_pulse", 64'(done_count), 64'(done_before));
    rst = 1'b0;
    ready_mode = 0;
    issue_dump();
    finish_dump("after_rst");

    // Writes racing the dump: reg 20 before its READ, reg 3 after its beat.
    snap();
    exp_rf[20] = 32'h0000_00AB;
    issue_dump();
    rf[20] = 32'h0000_00AB;
    begin
      int n = 0;
      while (beats_seen < 4 && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    rf[3] = 32'hFFFF_FFFF;
    finish_dump("writes");

    // Randomized contents and sink behaviour.
    ready_mode = 3;
    repeat (2) begin
      for (int i = 0; i < N; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      snap();
      issue_dump();
      finish_dump("random");
    end

    // Sparse file: only regs 1, 10 and 31 nonzero.
    ready_mode = 0;
    for (int i = 0; i < N; i++) rf[i] = 32'h0;
    rf[1]  = 32'h0000_0011;
    rf[10] = 32'h0000_0A0A;
    rf[31] = 32'h8000_0001;
    snap();
    issue_dump();
    finish_dump("sparse");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
